cla_pipe_adder: RTL and testbench
=================================

// Module: cla_pipe_adder
// PURPOSE
//  Parametrised, pipelined carry-lookahead adder/subtractor. Successor to the 4-bit domino CLU:
//  generalises to WIDTH bits in GROUP-bit lookahead groups, with a second-level group-carry unit.
//  Adds subtract mode, overflow and block G/P outputs for cascading. Two registered stages with a
//  valid/ready handshake and backpressure. Sits in the Adder datapath in place of the static CLU chain.
// PARAMETERS
//  WIDTH  16  operand width in bits; a multiple of GROUP, range 4..64
//  GROUP  4   bits per lookahead group; only 4 is supported, matching the existing CLU
// PORTS
//  PHI        in   1      clock, rising-edge
//  RST_       in   1      synchronous reset, active-low
//  IN_VALID   in   1      input operands valid
//  IN_READY   out  1      block accepts operands this cycle
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B
//  CIN        in   1      carry in; ignored when SUB=1
//  SUB        in   1      1: A-B, computed as A+~B+1
//  OUT_VALID  out  1      result valid
//  OUT_READY  in   1      downstream accepts result
//  SUM        out  WIDTH  result
//  COUT       out  1      carry out of the MSB (for SUB, 1 = no borrow)
//  OVF        out  1      two's-complement overflow
//  BG         out  1      block generate, for cascading
//  BP         out  1      block propagate, for cascading
// BEHAVIOUR
//  Reset: while RST_=0 at a rising PHI edge, both stage-valid flags are cleared.
//   OUT_VALID=0 after that edge. SUM, COUT, OVF, BG and BP are driven to 0.
//   IN_READY=1 in the first cycle after reset is released.
//   Reset mid-operation discards all in-flight results; no partial output is produced.
//  Stage 1 (S1), registered on an accepted input:
//   Bi=B^{WIDTH{SUB}}, c0=SUB?1:CIN.
//   Per bit: g=A&Bi, p=A^Bi. Per group k: Gk and Pk from the standard 4-bit lookahead equations.
//   Registers p, the Gk/Pk vectors, c0, A[MSB] and Bi[MSB].
//  Stage 2 (S2), registered:
//   Group carries: C(k+1) = Gk | Pk&Ck, flattened lookahead, with C0=c0.
//   In-group carries: c(i+1) = gi | pi&ci, starting from Ck.
//   SUM = p ^ c. COUT = c[WIDTH].
//   OVF = (A[MSB]==Bi[MSB]) & (SUM[MSB]!=A[MSB]).
//   BG = group-level generate over all groups; BP = AND of all Pk.
//  Latency: exactly 2 PHI edges from acceptance to OUT_VALID when there is no backpressure.
//   Throughput is 1 result per cycle.
//  Handshake: a transfer occurs when VALID&READY are both 1 at the rising edge.
//   ready2 = !OUT_VALID | OUT_READY. ready1 = !v1 | ready2. IN_READY = ready1 (combinational).
//   Each stage loads when its upstream valid is 1 and its own ready is 1.
//   When a stage drains and receives no new data, its valid flag clears.
//  Stall: while OUT_VALID=1 and OUT_READY=0, SUM, COUT, OVF, BG and BP hold stable.
//   The S1 contents are held and no input data is lost.
//  Full pipe + stall: IN_READY=0. An IN_VALID asserted during a stall must be held by the source.
//  Simultaneous events: output drain, S1->S2 move and a new input accept may all occur in one edge.
//   Sustained throughput is 1 result per cycle.
//  Wrap-around: results are modulo 2^WIDTH; the carry appears only on COUT, e.g. FFFF+0001 -> SUM=0000, COUT=1.
//  Outputs while OUT_VALID=0 are don't-care; the bench must not check them.
// TESTING (WIDTH=16)
//  1 Reset: hold RST_=0 for 3 edges, then release -> OUT_VALID=0, IN_READY=1, SUM=0000.
//  2 Add: A=1234, B=4321, CIN=1, SUB=0 -> 2 edges later SUM=5556, COUT=0, OVF=0.
//  3 Full carry ripple: A=FFFF, B=0000, CIN=1 -> SUM=0000, COUT=1, BP=1, BG=0.
//   Then A=7FFF, B=0001 -> SUM=8000, OVF=1.
//  4 Subtract: A=0005, B=0007, SUB=1, CIN=0 -> SUM=FFFE, COUT=0.
//   Then A=8000, B=0001, SUB=1 -> SUM=7FFF, OVF=1, COUT=1.
//  5 Backpressure: stream 4 operands with OUT_READY=0 from cycle 3 -> IN_READY=0 once both stages are full.
//   Outputs hold; on release, results arrive in order with none lost or duplicated.
//  6 Reset mid-stream: pull RST_ low with 2 results in flight -> OUT_VALID=0 the next edge.
//   Neither result ever appears after reset is released.
//  Plus a random scoreboard: 10k random A/B/CIN/SUB values with random OUT_READY, compared against A+B+CIN / A-B.

Source files
------------

// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for the pipelined carry-lookahead adder.
// The master side supplies operands and accepts results; the slave side is the adder.
interface cla_pipe_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             bg;
  logic             bp;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, bg, bp
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, bg, bp
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Stage 1 forms bit and 4-bit group generate/propagate; stage 2 resolves carries and the sum.
module cla_pipe_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = 4
) (
  input logic             phi,
  input logic             rst_,
  cla_pipe_adder_if.slave bus
);
  localparam int unsigned NG  = WIDTH / GROUP;
  localparam int unsigned MSB = WIDTH - 1;

  // Stage 1 combinational terms
  logic [WIDTH-1:0] bi_c;
  logic [WIDTH-1:0] g_c;
  logic [WIDTH-1:0] p_c;
  logic [NG-1:0]    gg_c;
  logic [NG-1:0]    gp_c;
  logic [3*NG-1:0]  gl_c;
  logic             c0_c;

  // Stage 1 registers
  logic             v1;
  logic [WIDTH-1:0] p_q;
  logic [3*NG-1:0]  gl_q;
  logic [NG-1:0]    gg_q;
  logic [NG-1:0]    gp_q;
  logic             c0_q;
  logic             amsb_q;
  logic             bmsb_q;

  // Stage 2 combinational terms
  logic [NG:0]      gc_c;
  logic [NG-1:0]    gen_c;
  logic [WIDTH-1:0] c_c;
  logic [WIDTH-1:0] sum_c;
  logic             ovf_c;

  // Stage 2 registers
  logic             v2;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             bg_q;
  logic             bp_q;

  logic ready1_c;
  logic ready2_c;

  assign ready2_c = !v2 || bus.out_ready;
  assign ready1_c = !v1 || ready2_c;

  // Subtract is A + ~B + 1, so the carry-in is forced high.
  assign bi_c = bus.b ^ {WIDTH{bus.sub}};
  assign c0_c = bus.sub | bus.cin;
  assign g_c  = bus.a & bi_c;
  assign p_c  = bus.a ^ bi_c;

  for (genvar k = 0; k < NG; k++) begin : g_s1
    localparam int unsigned B = GROUP * k;
    assign gg_c[k] = g_c[B+3]
                   | (p_c[B+3] & g_c[B+2])
                   | (p_c[B+3] & p_c[B+2] & g_c[B+1])
                   | (p_c[B+3] & p_c[B+2] & p_c[B+1] & g_c[B]);
    assign gp_c[k] = &p_c[B+3:B];
    // The top generate bit of each group only matters through Gk.
    assign gl_c[3*k +: 3] = g_c[B+2:B];
  end

  assign gc_c[0] = c0_q;

  for (genvar k = 0; k < NG; k++) begin : g_s2
    localparam int unsigned B = GROUP * k;
    logic [k:0] terms;
    for (genvar j = 0; j <= k; j++) begin : g_term
      if (j == k) begin : g_last
        assign terms[j] = gg_q[j];
      end else begin : g_mid
        assign terms[j] = gg_q[j] & (&gp_q[k:j+1]);
      end
    end
    // Flattened group carry: every group generate plus the carry-in, each gated by the propagate run above it.
    assign gen_c[k]  = |terms;
    assign gc_c[k+1] = gen_c[k] | (c0_q & (&gp_q[k:0]));

    assign c_c[B]   = gc_c[k];
    assign c_c[B+1] = gl_q[3*k] | (p_q[B] & gc_c[k]);
    assign c_c[B+2] = gl_q[3*k+1] | (p_q[B+1] & gl_q[3*k])
                    | (p_q[B+1] & p_q[B] & gc_c[k]);
    assign c_c[B+3] = gl_q[3*k+2] | (p_q[B+2] & gl_q[3*k+1])
                    | (p_q[B+2] & p_q[B+1] & gl_q[3*k])
                    | (p_q[B+2] & p_q[B+1] & p_q[B] & gc_c[k]);
  end

  assign sum_c = p_q ^ c_c;
  assign ovf_c = (amsb_q == bmsb_q) && (sum_c[MSB] != amsb_q);

  // Pipeline registers: each stage loads when it is ready and upstream is valid.
  always_ff @(posedge phi) begin
    if (!rst_) begin
      v1     <= 1'b0;
      p_q    <= '0;
      gl_q   <= '0;
      gg_q   <= '0;
      gp_q   <= '0;
      c0_q   <= 1'b0;
      amsb_q <= 1'b0;
      bmsb_q <= 1'b0;
      v2     <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      bg_q   <= 1'b0;
      bp_q   <= 1'b0;
    end else begin
      if (ready1_c) begin
        v1 <= bus.in_valid;
      end
      if (ready1_c && bus.in_valid) begin
        p_q    <= p_c;
        gl_q   <= gl_c;
        gg_q   <= gg_c;
        gp_q   <= gp_c;
        c0_q   <= c0_c;
        amsb_q <= bus.a[MSB];
        bmsb_q <= bi_c[MSB];
      end
      if (ready2_c) begin
        v2 <= v1;
      end
      if (ready2_c && v1) begin
        sum_q  <= sum_c;
        cout_q <= gc_c[NG];
        ovf_q  <= ovf_c;
        bg_q   <= gen_c[NG-1];
        bp_q   <= &gp_q;
      end
    end
  end

  assign bus.in_ready  = ready1_c;
  assign bus.out_valid = v2;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.bg        = bg_q;
  assign bus.bp        = bp_q;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: directed add/subtract/stall/reset cases plus a random stream
// checked against an arithmetic model.
module tb_cla_pipe_adder;
  localparam int unsigned WIDTH = 16;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        bg;
    logic        bp;
  } res_t;

  logic phi = 1'b0;
  logic rst_;

  cla_pipe_adder_if #(.WIDTH(WIDTH)) bus ();

  cla_pipe_adder #(.WIDTH(WIDTH), .GROUP(4)) dut (
    .phi  (phi),
    .rst_ (rst_),
    .bus  (bus)
  );

  always #5 phi = ~phi;

  int   n_cmp = 0;
  int   n_err = 0;
  res_t exp_q[$];
  bit   stalled_prev = 1'b0;
  res_t held;
  logic acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
    res_t        r;
    logic [15:0] bi;
    logic [16:0] full;
    logic [16:0] gsum;
    int          sa;
    int          sb;
    int          sr;
    bi   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bi} + 17'(sub | cin);
    gsum = {1'b0, a} + {1'b0, bi};
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    sr   = sub ? (sa - sb) : (sa + sb + int'(cin));
    r.sum  = full[15:0];
    r.cout = full[16];
    r.ovf  = (sr > 32767) || (sr < -32768);
    r.bg   = gsum[16];
    r.bp   = &(a ^ bi);
    return r;
  endfunction

  function automatic res_t observed();
    return {bus.sum, bus.cout, bus.ovf, bus.bg, bus.bp};
  endfunction

  // One clock: sample just after the inputs settle, score transfers, then advance to the next falling edge.
  task automatic tick();
    res_t e;
    res_t o;
    #1;
    acc = 1'b0;
    if (rst_) begin
      o = observed();
      if (bus.out_valid) begin
        if (stalled_prev) check("stall_hold", 32'(o), 32'(held));
        if (bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", 32'(1), 32'(0));
          end else begin
            e = exp_q.pop_front();
            check("result", 32'(o), 32'(e));
          end
        end
      end else if (stalled_prev) begin
        check("stall_valid", 32'(0), 32'(1));
      end
      stalled_prev = bus.out_valid && !bus.out_ready;
      held = o;
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
        acc = 1'b1;
      end
    end else begin
      stalled_prev = 1'b0;
    end
    @(posedge phi);
    @(negedge phi);
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
    bus.in_valid = 1'b1;
    bus.a   = a;
    bus.b   = b;
    bus.cin = cin;
    bus.sub = sub;
    for (int t = 0; t < 50; t++) begin
      tick();
      if (acc) break;
    end
    if (!acc) check("send_timeout", 32'(0), 32'(1));
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int sent;
    int cyc;
    rst_          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge phi);
    repeat (3) tick();
    rst_ = 1'b1;
    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_in_ready", 32'(bus.in_ready), 32'(1));
    check("rst_sum", 32'(bus.sum), 32'(0));

    // Plain add with exact two-edge latency
    bus.out_ready = 1'b1;
    send(16'h1234, 16'h4321, 1'b1, 1'b0);
    check("lat_edge1", 32'(bus.out_valid), 32'(0));
    tick();
    check("lat_edge2", 32'(bus.out_valid), 32'(1));
    check("add_sum", 32'(bus.sum), 32'h5556);
    tick();
    repeat (2) tick();

    // Full carry ripple and signed overflow
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    repeat (4) tick();

    // Subtract
    send(16'h0005, 16'h0007, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1);
    repeat (4) tick();

    // Backpressure: fill both stages, hold the third operand while stalled
    bus.out_ready = 1'b0;
    send(16'h0101, 16'h0202, 1'b0, 1'b0);
    send(16'h1111, 16'h2222, 1'b1, 1'b0);
    bus.in_valid = 1'b1;
    bus.a   = 16'hA5A5;
    bus.b   = 16'h5A5A;
    bus.cin = 1'b1;
    bus.sub = 1'b0;
    repeat (3) begin
      #1 check("full_in_ready", 32'(bus.in_ready), 32'(0));
      tick();
    end
    bus.out_ready = 1'b1;
    send(16'hA5A5, 16'h5A5A, 1'b1, 1'b0);
    send(16'h0F0F, 16'h00F1, 1'b0, 1'b1);
    repeat (6) tick();
    check("bp_drained", 32'(exp_q.size()), 32'(0));

    // Reset with two results in flight
    send(16'h0042, 16'h0017, 1'b0, 1'b0);
    send(16'h3000, 16'h0300, 1'b0, 1'b1);
    bus.out_ready = 1'b0;
    rst_ = 1'b0;
    tick();
    check("rst_mid_valid", 32'(bus.out_valid), 32'(0));
    exp_q.delete();
    rst_ = 1'b1;
    bus.out_ready = 1'b1;
    repeat (5) begin
      check("rst_no_ghost", 32'(bus.out_valid), 32'(0));
      tick();
    end

    // Random stream with random backpressure; a raised valid is held until accepted
    sent = 0;
    cyc  = 0;
    bus.a   = 16'($urandom);
    bus.b   = 16'($urandom);
    bus.cin = 1'($urandom);
    bus.sub = 1'($urandom);
    bus.in_valid = 1'b1;
    while (sent < 10000 && cyc < 60000) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (!bus.in_valid) bus.in_valid = ($urandom_range(0, 9) != 0);
      tick();
      cyc++;
      if (acc) begin
        sent++;
        bus.a   = 16'($urandom);
        bus.b   = 16'($urandom);
        bus.cin = 1'($urandom);
        bus.sub = 1'($urandom);
        bus.in_valid = ($urandom_range(0, 9) != 0);
      end
    end
    check("rand_sent", 32'(sent), 32'(10000));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (8) tick();
    check("rand_drained", 32'(exp_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
